// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte to the keyboard,
//   for example LED set 0xED, reset 0xFF or typematic 0xF3. Both PS/2 lines
//   are open-drain: an oe of 1 pulls the line low and an oe of 0 releases it.
//   While a frame is in progress, rx_inhibit tells the neighbouring scan-code
//   receiver to ignore clock edges.
//
//   Optional feature macro: PS2_TX_TIMEOUT_EN. When it is defined, a watchdog
//   aborts a frame that the device never finishes. This build also exposes
//   the TIMEOUT_CYC parameter.
//
// Parameters
//   INHIBIT_CYC  number of cycles kclk is held low before the request-to-send
//   TIMEOUT_CYC  watchdog limit in cycles (only with PS2_TX_TIMEOUT_EN)
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   tx_data    command byte, captured when tx_valid && tx_ready
//   tx_valid   request to send
//   tx_ready   high only while idle
//   kclk_in    raw PS/2 clock pin level
//   kdata_in   raw PS/2 data pin level
//   kclk_oe    1 = pull kclk low
//   kdata_oe   1 = pull kdata low
//   rx_inhibit high whenever a frame is in progress
//   tx_done    one-cycle pulse: frame sent and acknowledged
//   tx_err     one-cycle pulse: nack (or timeout when enabled)
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 5000
`ifdef PS2_TX_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 750000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_err
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAITIDLE,
        ERR
    } state_t;

    // One timer is shared: it counts the inhibit period and, when enabled,
    // the watchdog. 23 bits covers the watchdog range.
    localparam int TW = 23;

    state_t        state, state_next;
    logic [9:0]    frame, frame_next;
    logic [3:0]    bitcnt, bitcnt_next;
    logic [TW-1:0] timer, timer_next;
    logic          kclk_oe_next, kdata_oe_next, done_next, err_next;

    logic kclk_s1, kclk_s2, kclk_prev;
    logic kdata_s1, kdata_s2;
    logic fall;

    // The synchronisers reset to the idle-high bus level. This keeps a
    // phantom falling edge from appearing just after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kclk_s1   <= 1'b1;
            kclk_s2   <= 1'b1;
            kclk_prev <= 1'b1;
            kdata_s1  <= 1'b1;
            kdata_s2  <= 1'b1;
        end else begin
            kclk_s1   <= kclk_in;
            kclk_s2   <= kclk_s1;
            kclk_prev <= kclk_s2;
            kdata_s1  <= kdata_in;
            kdata_s2  <= kdata_s1;
        end
    end

    assign fall = kclk_prev & ~kclk_s2;

    // All line enables and the done/err pulses are registered, so the pins
    // never see combinational glitches. Reset releases both lines at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            frame    <= '0;
            bitcnt   <= '0;
            timer    <= '0;
            kclk_oe  <= 1'b0;
            kdata_oe <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            state    <= state_next;
            frame    <= frame_next;
            bitcnt   <= bitcnt_next;
            timer    <= timer_next;
            kclk_oe  <= kclk_oe_next;
            kdata_oe <= kdata_oe_next;
            tx_done  <= done_next;
            tx_err   <= err_next;
        end
    end

    always_comb begin
        state_next    = state;
        frame_next    = frame;
        bitcnt_next   = bitcnt;
        timer_next    = timer;
        kclk_oe_next  = kclk_oe;
        kdata_oe_next = kdata_oe;
        done_next     = 1'b0;
        err_next      = 1'b0;

        case (state)
            IDLE: begin
                kclk_oe_next  = 1'b0;
                kdata_oe_next = 1'b0;
                if (tx_valid) begin
                    // The frame goes out LSB first: d0..d7, odd parity, stop.
                    frame_next   = {1'b1, ~^tx_data, tx_data};
                    bitcnt_next  = '0;
                    timer_next   = '0;
                    kclk_oe_next = 1'b1;
                    state_next   = INHIBIT;
                end
            end

            INHIBIT: begin
                if (timer == TW'(INHIBIT_CYC - 1)) begin
                    // The start bit (data low) is driven on the same edge
                    // that releases the clock.
                    timer_next    = '0;
                    kclk_oe_next  = 1'b0;
                    kdata_oe_next = 1'b1;
                    state_next    = REQ;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end

            REQ, SEND: begin
                if (fall) begin
                    // Falls 1..10 present frame bits 0..9. The stop bit is 1,
                    // so the tenth fall releases the data line.
                    kdata_oe_next = ~frame[0];
                    frame_next    = {1'b1, frame[9:1]};
                    if (bitcnt == 4'd9) begin
                        state_next = ACK;
                    end else begin
                        bitcnt_next = bitcnt + 1'b1;
                        state_next  = SEND;
                    end
                end
            end

            ACK: begin
                if (fall) begin
                    if (kdata_s2) begin
                        err_next   = 1'b1;
                        state_next = ERR;
                    end else begin
                        state_next = WAITIDLE;
                    end
                end
            end

            WAITIDLE: begin
                if (kclk_s2 && kdata_s2) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end

            ERR: begin
                kclk_oe_next  = 1'b0;
                kdata_oe_next = 1'b0;
                state_next    = IDLE;
            end

            default: begin
                kclk_oe_next  = 1'b0;
                kdata_oe_next = 1'b0;
                state_next    = IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // The watchdog runs from the request-to-send until the bus goes idle.
        // It overrides any normal transition, so done and err stay exclusive.
        if (state inside {REQ, SEND, ACK, WAITIDLE}) begin
            if (timer == TW'(TIMEOUT_CYC - 1)) begin
                kclk_oe_next  = 1'b0;
                kdata_oe_next = 1'b0;
                done_next     = 1'b0;
                err_next      = 1'b1;
                state_next    = ERR;
            end else begin
                timer_next = timer + 1'b1;
            end
        end
`endif
    end

    assign tx_ready   = (state == IDLE);
    assign rx_inhibit = (state != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//   Directed bench for ps2_host_tx. A small PS/2 device model clocks the
//   frame, reads back the bits the host drives and answers with an ack or a
//   nack. Expected frames are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int INHIBIT_CYC = 5000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       kclk_in, kdata_in;
    logic       kclk_oe, kdata_oe;
    logic       rx_inhibit, tx_done, tx_err;

    logic dev_clk_low, dev_data_low;

    int vectors = 0;
    int miscompares = 0;
    int done_total = 0;
    int err_total = 0;
    int both_total = 0;

    // Wired-AND open-drain bus with pull-ups.
    assign kclk_in  = ~(kclk_oe | dev_clk_low);
    assign kdata_in = ~(kdata_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYC(INHIBIT_CYC)
`ifdef PS2_TX_TIMEOUT_EN
        , .TIMEOUT_CYC(1000)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .kclk_in    (kclk_in),
        .kdata_in   (kdata_in),
        .kclk_oe    (kclk_oe),
        .kdata_oe   (kdata_oe),
        .rx_inhibit (rx_inhibit),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (tx_done) done_total <= done_total + 1;
        if (tx_err) err_total <= err_total + 1;
        if (tx_done && tx_err) both_total <= both_total + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data);
        @(negedge clk);
        tx_data  = data;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Runs one frame. abort_fall > 0 asserts reset right after that fall.
    task automatic runFrame(input string tag, input logic [7:0] data,
                            input logic [9:0] exp_frame, input logic exp_parity,
                            input bit ack, input bit poke_valid, input int abort_fall);
        logic [9:0] seen;
        int cnt;
        int done0, err0;
        done0 = done_total;
        err0  = err_total;
        seen  = '0;

        applyStimulus(data);
        checkOutput({tag, ".ready_drop"}, 32'(tx_ready), 32'd0);
        checkOutput({tag, ".rx_inhibit"}, 32'(rx_inhibit), 32'd1);

        cnt = 0;
        while (kclk_oe && cnt < 6000) begin
            if (poke_valid && cnt == 50) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
            end
            if (poke_valid && cnt == 53) tx_valid = 1'b0;
            cnt++;
            @(negedge clk);
        end
        checkOutput({tag, ".inhibit_len"}, 32'(cnt), 32'(INHIBIT_CYC));
        checkOutput({tag, ".start_bit"}, 32'(kdata_oe), 32'd1);

        for (int i = 1; i <= 11; i++) begin
            repeat (10) @(negedge clk);
            if (i == 11 && ack) dev_data_low = 1'b1;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (10) @(negedge clk);
            if (i <= 10) seen[i-1] = kdata_in;
            if (abort_fall == i) begin
                checkOutput({tag, ".pre_abort_oe"}, 32'(kdata_oe), 32'd1);
                rst = 1'b1;
                #1;
                checkOutput({tag, ".abort_oe"}, {30'd0, kclk_oe, kdata_oe}, 32'd0);
                checkOutput({tag, ".abort_ready"}, 32'(tx_ready), 32'd1);
                dev_clk_low = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                repeat (20) @(negedge clk);
                checkOutput({tag, ".abort_pulses"}, 32'((done_total - done0) + (err_total - err0)), 32'd0);
                return;
            end
            dev_clk_low = 1'b0;
        end
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
        repeat (20) @(negedge clk);

        checkOutput({tag, ".frame"}, 32'(seen), 32'(exp_frame));
        checkOutput({tag, ".parity"}, 32'(seen[8]), 32'(exp_parity));
        checkOutput({tag, ".done_cnt"}, 32'(done_total - done0), ack ? 32'd1 : 32'd0);
        checkOutput({tag, ".err_cnt"}, 32'(err_total - err0), ack ? 32'd0 : 32'd1);
        checkOutput({tag, ".ready_back"}, 32'(tx_ready), 32'd1);
        checkOutput({tag, ".lines_free"}, {30'd0, kclk_oe, kdata_oe}, 32'd0);
    endtask

    initial begin
        int cnt;
        int err0;
        rst          = 1'b1;
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst.ready", 32'(tx_ready), 32'd1);
        checkOutput("rst.inhibit", 32'(rx_inhibit), 32'd0);
        checkOutput("rst.oe", {30'd0, kclk_oe, kdata_oe}, 32'd0);
        checkOutput("rst.pulses", {30'd0, tx_done, tx_err}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("idle.ready", 32'(tx_ready), 32'd1);

        runFrame("ed",    8'hED, 10'h3ED, 1'b1, 1'b1, 1'b0, 0);
        runFrame("01",    8'h01, 10'h201, 1'b0, 1'b1, 1'b1, 0);
        runFrame("00",    8'h00, 10'h300, 1'b1, 1'b1, 1'b0, 0);
        runFrame("nack",  8'hF4, 10'h2F4, 1'b0, 1'b0, 1'b0, 0);
        runFrame("abort", 8'hF3, 10'h3F3, 1'b1, 1'b1, 1'b0, 4);
        runFrame("ff",    8'hFF, 10'h3FF, 1'b1, 1'b1, 1'b0, 0);

        // Silent device: the frame stalls in the request-to-send state.
        err0 = err_total;
        applyStimulus(8'hA5);
        cnt = 0;
        while (kclk_oe && cnt < 6000) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("hang.req", 32'(kdata_oe), 32'd1);
`ifdef PS2_TX_TIMEOUT_EN
        cnt = 0;
        while (!tx_err && cnt < 1200) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("hang.timeout_cyc", 32'(cnt), 32'd1000);
        checkOutput("hang.timeout_oe", {30'd0, kclk_oe, kdata_oe}, 32'd0);
        checkOutput("hang.no_done", 32'(tx_done), 32'd0);
        @(negedge clk);
        checkOutput("hang.ready_back", 32'(tx_ready), 32'd1);
`else
        repeat (2000) @(negedge clk);
        checkOutput("hang.still_req", {28'd0, tx_ready, kclk_oe, kdata_oe, rx_inhibit}, 32'b0011);
        checkOutput("hang.no_err", 32'(err_total - err0), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("hang.recover", 32'(tx_ready), 32'd1);
`endif
        checkOutput("never_both", 32'(both_total), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
